// File: rtl/cex_controller.sv
// Conditional-execution (CEX) sequencer between decode and execute for the XM23 pipeline.
// Optional saturating squash counter enabled by defining CEX_PERF_CNT_EN.
module cex_controller #(
    parameter int TF_W   = 3,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              cex_valid,
    input  logic [3:0]        cex_cond,
    input  logic [TF_W-1:0]   cex_t,
    input  logic [TF_W-1:0]   cex_f,
    input  logic              psw_n,
    input  logic              psw_z,
    input  logic              psw_c,
    input  logic              psw_v,
    output logic              exec_en,
    output logic              cex_active,
    output logic              nest_err,
    output logic [PERF_W-1:0] supp_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_THEN = 2'd1,
        ST_ELSE = 2'd2
    } state_t;

    localparam logic [TF_W-1:0] TF_ZERO = '0;
    localparam logic [TF_W-1:0] TF_ONE  = TF_W'(1);

    state_t          r_state;
    logic            r_cond_q;
    logic [TF_W-1:0] r_t_rem;
    logic [TF_W-1:0] r_f_rem;
    logic            r_nest_err;

    logic            w_adv;
    logic            w_cond;

    assign w_adv = inst_valid & ~stall;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_cond = 1'b0;
        case (cex_cond)
            4'h0: w_cond = psw_z;
            4'h1: w_cond = ~psw_z;
            4'h2: w_cond = psw_c;
            4'h3: w_cond = ~psw_c;
            4'h4: w_cond = psw_n;
            4'h5: w_cond = ~psw_n;
            4'h6: w_cond = psw_v;
            4'h7: w_cond = ~psw_v;
            4'h8: w_cond = psw_c & ~psw_z;
            4'h9: w_cond = ~psw_c | psw_z;
            4'hA: w_cond = (psw_n == psw_v);
            4'hB: w_cond = (psw_n != psw_v);
            4'hC: w_cond = ~psw_z & (psw_n == psw_v);
            4'hD: w_cond = psw_z | (psw_n != psw_v);
            4'hE: w_cond = 1'b1;
            4'hF: w_cond = 1'b0;
            default: w_cond = 1'b0;
        endcase
    end

    // The CEX instruction itself is seen in IDLE, so it always commits.
    always_comb begin
        exec_en = 1'b1;
        case (r_state)
            ST_THEN: exec_en = r_cond_q;
            ST_ELSE: exec_en = ~r_cond_q;
            default: exec_en = 1'b1;
        endcase
    end

    assign cex_active = (r_state != ST_IDLE);
    assign nest_err   = r_nest_err;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cond_q   <= 1'b0;
            r_t_rem    <= TF_ZERO;
            r_f_rem    <= TF_ZERO;
            r_nest_err <= 1'b0;
        end else if (flush) begin
            // cond_q is left alone; it is only meaningful inside a block.
            r_state    <= ST_IDLE;
            r_t_rem    <= TF_ZERO;
            r_f_rem    <= TF_ZERO;
            r_nest_err <= 1'b0;
        end else begin
            r_nest_err <= 1'b0;
            if (w_adv) begin
                case (r_state)
                    ST_IDLE: begin
                        if (cex_valid) begin
                            r_cond_q <= w_cond;
                            r_t_rem  <= cex_t;
                            r_f_rem  <= cex_f;
                            if (cex_t != TF_ZERO) begin
                                r_state <= ST_THEN;
                            end else if (cex_f != TF_ZERO) begin
                                r_state <= ST_ELSE;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    ST_THEN: begin
                        r_nest_err <= cex_valid;
                        r_t_rem    <= r_t_rem - TF_ONE;
                        if (r_t_rem == TF_ONE) begin
                            r_state <= (r_f_rem != TF_ZERO) ? ST_ELSE : ST_IDLE;
                        end
                    end
                    ST_ELSE: begin
                        r_nest_err <= cex_valid;
                        r_f_rem    <= r_f_rem - TF_ONE;
                        if (r_f_rem == TF_ONE) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CEX_PERF_CNT_EN
    logic [PERF_W-1:0] r_supp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_supp_cnt <= '0;
        end else if (w_adv && !exec_en && (r_supp_cnt != {PERF_W{1'b1}})) begin
            r_supp_cnt <= r_supp_cnt + PERF_W'(1);
        end
    end

    assign supp_cnt = r_supp_cnt;
`else
    assign supp_cnt = '0;
`endif

endmodule

// File: tb/tb_cex_controller.sv
// Self-checking bench for cex_controller: expected exec_en per advancing instruction is
// queued when the instruction is driven and compared when it reaches the DUT.
module tb_cex_controller;

    localparam int TF_W   = 3;
    localparam int PERF_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_valid;
    logic              stall;
    logic              flush;
    logic              cex_valid;
    logic [3:0]        cex_cond;
    logic [TF_W-1:0]   cex_t;
    logic [TF_W-1:0]   cex_f;
    logic              psw_n;
    logic              psw_z;
    logic              psw_c;
    logic              psw_v;
    logic              exec_en;
    logic              cex_active;
    logic              nest_err;
    logic [PERF_W-1:0] supp_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_supp = 0;
    logic sb_q[$];

    cex_controller #(.TF_W(TF_W), .PERF_W(PERF_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .stall      (stall),
        .flush      (flush),
        .cex_valid  (cex_valid),
        .cex_cond   (cex_cond),
        .cex_t      (cex_t),
        .cex_f      (cex_f),
        .psw_n      (psw_n),
        .psw_z      (psw_z),
        .psw_c      (psw_c),
        .psw_v      (psw_v),
        .exec_en    (exec_en),
        .cex_active (cex_active),
        .nest_err   (nest_err),
        .supp_cnt   (supp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle at the falling edge; an advancing, unflushed instruction queues its
    // expected exec_en, which is then popped and compared against the DUT.
    task automatic step(input string tag, input logic v, input logic s, input logic fl,
                        input logic cx, input logic [3:0] c, input logic [TF_W-1:0] t,
                        input logic [TF_W-1:0] f, input logic exp_en);
        logic want;
        @(negedge clk);
        inst_valid = v;
        stall      = s;
        flush      = fl;
        cex_valid  = cx;
        cex_cond   = c;
        cex_t      = t;
        cex_f      = f;
        if (v && !s && !fl) begin
            sb_q.push_back(exp_en);
            if (!exp_en) exp_supp++;
        end
        #1;
        if (v && !s && !fl) begin
            want = sb_q.pop_front();
            check(tag, exec_en, want);
        end
    endtask

    task automatic instr(input string tag, input logic exp_en);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, exp_en);
    endtask

    task automatic cex(input string tag, input logic [3:0] c, input logic [TF_W-1:0] t,
                       input logic [TF_W-1:0] f);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b1, c, t, f, 1'b1);
    endtask

    // Let the last driven cycle clock in, then park the inputs idle.
    task automatic after_edge();
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        cex_valid  = 1'b0;
    endtask

    task automatic set_flags(input logic n, input logic z, input logic c, input logic v);
        psw_n = n;
        psw_z = z;
        psw_c = c;
        psw_v = v;
    endtask

    task automatic check_supp(input string tag);
`ifdef CEX_PERF_CNT_EN
        check(tag, 32'(supp_cnt), 32'(exp_supp));
`else
        check(tag, 32'(supp_cnt), 32'd0);
`endif
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic n, input logic z,
                                      input logic cy, input logic v);
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst        = 1'b1;
        inst_valid = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        cex_valid  = 1'b0;
        cex_cond   = 4'h0;
        cex_t      = '0;
        cex_f      = '0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_exec_en", exec_en, 1'b1);
        check("rst_active", cex_active, 1'b0);
        check("rst_nest", nest_err, 1'b0);
        check("rst_supp", 32'(supp_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // EQ true, T=2 F=1
        set_flags(1'b0, 1'b1, 1'b0, 1'b0);
        cex("t1_cex", 4'h0, 3'd2, 3'd1);
        instr("t1_s1", 1'b1);
        instr("t1_s2", 1'b1);
        check("t1_active_in", cex_active, 1'b1);
        instr("t1_s3", 1'b0);
        after_edge();
        check("t1_active_out", cex_active, 1'b0);
        instr("t1_s4", 1'b1);

        // EQ false, T=2 F=2
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        cex("t2_cex", 4'h0, 3'd2, 3'd2);
        instr("t2_s1", 1'b0);
        instr("t2_s2", 1'b0);
        instr("t2_s3", 1'b1);
        instr("t2_s4", 1'b1);
        after_edge();
        check("t2_active_out", cex_active, 1'b0);
        check_supp("t2_supp");

        // GE false, T=0 F=3: straight to ELSE
        set_flags(1'b1, 1'b0, 1'b0, 1'b0);
        cex("t3_cex", 4'hA, 3'd0, 3'd3);
        after_edge();
        check("t3_active", cex_active, 1'b1);
        instr("t3_s1", 1'b1);
        instr("t3_s2", 1'b1);
        instr("t3_s3", 1'b1);
        after_edge();
        check("t3_active_out", cex_active, 1'b0);

        // TR T=3 F=0 with two stall cycles and a bubble
        cex("t4_cex", 4'hE, 3'd3, 3'd0);
        instr("t4_s1", 1'b1);
        step("t4_stall1", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b1);
        check("t4_stall1_en", exec_en, 1'b1);
        step("t4_stall2", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b1);
        check("t4_stall2_act", cex_active, 1'b1);
        step("t4_bubble", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b1);
        instr("t4_s2", 1'b1);
        after_edge();
        check("t4_active_mid", cex_active, 1'b1);
        instr("t4_s3", 1'b1);
        after_edge();
        check("t4_active_out", cex_active, 1'b0);

        // Every condition code with random flags, T=1 F=1
        for (int code = 0; code < 16; code++) begin
            logic [3:0] fl4;
            logic       e;
            fl4 = 4'($urandom_range(0, 15));
            set_flags(fl4[3], fl4[2], fl4[1], fl4[0]);
            e = ref_cond(4'(code), fl4[3], fl4[2], fl4[1], fl4[0]);
            cex($sformatf("cc%0h_cex", code), 4'(code), 3'd1, 3'd1);
            instr($sformatf("cc%0h_then", code), e);
            instr($sformatf("cc%0h_else", code), !e);
        end
        after_edge();
        check("cc_active_out", cex_active, 1'b0);
        check_supp("cc_supp");

        // FL T=3 F=2, flush after slot 1 carrying a CEX that must be discarded
        cex("t5_cex", 4'hF, 3'd3, 3'd2);
        instr("t5_s1", 1'b0);
        step("t5_flush", 1'b1, 1'b0, 1'b1, 1'b1, 4'hE, 3'd2, 3'd0, 1'b1);
        after_edge();
        check("t5_active_flush", cex_active, 1'b0);
        check("t5_en_flush", exec_en, 1'b1);
        instr("t5_p1", 1'b1);
        instr("t5_p2", 1'b1);
        after_edge();
        check("t5_active_out", cex_active, 1'b0);

        // Nested CEX in slot 1 of a true T=2 F=1 block, then async reset mid-ELSE
        set_flags(1'b0, 1'b1, 1'b0, 1'b0);
        cex("t6_cex", 4'h0, 3'd2, 3'd1);
        step("t6_nested", 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 3'd7, 3'd7, 1'b1);
        instr("t6_s2", 1'b1);
        check("t6_nest_pulse", nest_err, 1'b1);
        after_edge();
        check("t6_nest_clear", nest_err, 1'b0);
        check("t6_else_active", cex_active, 1'b1);
        check("t6_else_en", exec_en, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_en", exec_en, 1'b1);
        check("t6_rst_active", cex_active, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        exp_supp = 0;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        instr("t6_post", 1'b1);
        after_edge();
        check("t6_post_active", cex_active, 1'b0);
        check_supp("t6_supp");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
